// File: rtl/alu_issue_ctrl.sv
// Command-side issue/capture controller for the 4-bit ALU: holds operands for two ALU edges, then captures result/flags.
// Optional accumulator-as-operand-A feature enabled by defining ALU_ISSUE_ACC_EN.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_acc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic       rsp_err
);

    localparam int unsigned DW = 4;
    localparam logic [DW-1:0] OP_DIV = DW'(4'b0011);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W1   = 3'd1,
        W2   = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          err_q, err_d;
    logic [DW-1:0] op_a;
    logic [DW-1:0] alu_a_d, alu_b_d, alu_sel_d;
    logic [DW-1:0] rsp_result_d, rsp_flags_d;
    logic          rsp_err_d, rsp_valid_d, cmd_ready_d;

`ifdef ALU_ISSUE_ACC_EN
    logic [DW-1:0] acc_q;

    // Accumulator tracks the most recent captured ALU result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else if (state_q == CAP)
            acc_q <= alu_out;
    end

    assign op_a = cmd_acc ? acc_q : cmd_a;
`else
    logic unused_cmd_acc;
    assign unused_cmd_acc = cmd_acc;
    assign op_a           = cmd_a;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = W1;
            W1:      state_d = W2;
            W2:      state_d = CAP;
            CAP:     state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; handshake outputs are pre-decoded from the next state
    always_comb begin
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_sel_d    = alu_sel;
        err_d        = err_q;
        rsp_result_d = rsp_result;
        rsp_flags_d  = rsp_flags;
        rsp_err_d    = rsp_err;
        cmd_ready_d  = (state_d == IDLE);
        rsp_valid_d  = (state_d == RESP);
        if (state_q == IDLE && cmd_valid) begin
            alu_a_d   = op_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_op;
            err_d     = (cmd_op == OP_DIV) && (cmd_b == '0);
        end
        if (state_q == CAP) begin
            rsp_result_d = alu_out;
            rsp_flags_d  = {alu_carry, alu_zero, alu_negative, alu_overflow};
            rsp_err_d    = err_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            err_q      <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
        end else begin
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_sel    <= alu_sel_d;
            err_q      <= err_d;
            rsp_result <= rsp_result_d;
            rsp_flags  <= rsp_flags_d;
            rsp_err    <= rsp_err_d;
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: two-stage ALU model plus response scoreboard.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_acc;
    logic [3:0] cmd_op, cmd_a, cmd_b;
    logic [3:0] alu_a, alu_b, alu_sel, alu_out;
    logic       alu_carry, alu_zero, alu_negative, alu_overflow;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [3:0] rsp_result, rsp_flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] sb_q[$];   // {err, flags, result}

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // ALU model: result/carry/overflow-pre register on edge 1, zero/negative/overflow on edge 2
    logic [3:0] r_s1;
    logic       c_s1, v_s1;

    function automatic logic [5:0] alu_f(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic       v;
        s = 5'd0;
        v = 1'b0;
        case (sel)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; v = (a[3] == b[3]) && (s[3] != a[3]); end
            4'b0001: begin s = {1'b0, a} - {1'b0, b}; v = (a[3] != b[3]) && (s[3] != a[3]); end
            4'b0011: s = (b == 4'd0) ? 5'h0F : {1'b0, a / b};
            default: s = {1'b0, a & b};
        endcase
        return {v, s};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v_s1, c_s1, r_s1} <= 6'd0;
            alu_zero           <= 1'b0;
            alu_negative       <= 1'b0;
            alu_overflow       <= 1'b0;
        end else begin
            {v_s1, c_s1, r_s1} <= alu_f(alu_sel, alu_a, alu_b);
            alu_zero           <= (r_s1 == 4'd0);
            alu_negative       <= r_s1[3];
            alu_overflow       <= v_s1;
        end
    end
    assign alu_out   = r_s1;
    assign alu_carry = c_s1;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic acc,
                        input logic [3:0] er, input logic [3:0] ef, input logic ee);
        check_val("cmd_ready_pre", 16'(cmd_ready), 16'd1);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        sb_q.push_back({ee, ef, er});
    endtask

    task automatic wait_rsp(input string tag);
        int lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        check_val({tag, "_latency"}, 16'(lat), 16'd3);
    endtask

    task automatic cmp_rsp(input string tag, input logic [8:0] e);
        check_val({tag, "_result"}, 16'(rsp_result), 16'(e[3:0]));
        check_val({tag, "_flags"},  16'(rsp_flags),  16'(e[7:4]));
        check_val({tag, "_err"},    16'(rsp_err),    16'(e[8]));
    endtask

    task automatic collect(input string tag);
        logic [8:0] e;
        wait_rsp(tag);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
        cmp_rsp(tag, e);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val({tag, "_idle_ready"}, 16'(cmd_ready), 16'd1);
        check_val({tag, "_idle_valid"}, 16'(rsp_valid), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] e;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_acc = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        check_val("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        check_val("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check_val("rst_alu_drv", 16'({alu_a, alu_b, alu_sel}), 16'd0);
        check_val("rst_rsp", 16'({rsp_err, rsp_flags, rsp_result}), 16'd0);

        send(4'b0000, 4'd7, 4'd9, 1'b0, 4'h0, 4'b1100, 1'b0);
        collect("add_7_9");
        send(4'b0001, 4'd3, 4'd5, 1'b0, 4'hE, 4'b1010, 1'b0);
        collect("sub_3_5");
        send(4'b0011, 4'd9, 4'd0, 1'b0, 4'hF, 4'b0010, 1'b1);
        collect("div_9_0");
        send(4'b0000, 4'd2, 4'd3, 1'b0, 4'h5, 4'b0000, 1'b0);
        collect("add_2_3");
`ifdef ALU_ISSUE_ACC_EN
        send(4'b0000, 4'd0, 4'd4, 1'b1, 4'h9, 4'b0011, 1'b0);
`else
        send(4'b0000, 4'd0, 4'd4, 1'b1, 4'h4, 4'b0000, 1'b0);
`endif
        collect("add_acc_4");
        check_val("idle_hold_sel", 16'(alu_sel), 16'h0);
        check_val("idle_hold_b", 16'(alu_b), 16'h4);

        // Backpressure: response held, stray command ignored
        send(4'b0001, 4'd3, 4'd5, 1'b0, 4'hE, 4'b1010, 1'b0);
        wait_rsp("bp");
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
        for (int i = 0; i < 4; i++) begin
            cmp_rsp("bp_hold", e);
            check_val("bp_cmd_ready", 16'(cmd_ready), 16'd0);
            check_val("bp_rsp_valid", 16'(rsp_valid), 16'd1);
            if (i == 1) begin
                cmd_op = 4'b0000; cmd_a = 4'd1; cmd_b = 4'd1; cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            step();
        end
        check_val("bp_alu_sel_kept", 16'(alu_sel), 16'h1);
        check_val("bp_alu_a_kept", 16'(alu_a), 16'h3);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("bp_release_ready", 16'(cmd_ready), 16'd1);
        step(); step(); step(); step();
        check_val("bp_no_extra_rsp", 16'(rsp_valid), 16'd0);

        // Reset during W2 drops the in-flight command
        send(4'b0000, 4'd7, 4'd9, 1'b0, 4'h0, 4'b1100, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb_q.delete();
        check_val("midrst_rsp_valid", 16'(rsp_valid), 16'd0);
        check_val("midrst_cmd_ready", 16'(cmd_ready), 16'd1);
        check_val("midrst_alu_a", 16'(alu_a), 16'd0);
        step(); step(); step(); step();
        check_val("midrst_no_rsp", 16'(rsp_valid), 16'd0);
        send(4'b0000, 4'd1, 4'd1, 1'b0, 4'h2, 4'b0000, 1'b0);
        collect("add_1_1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
